// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared definitions for the 64-bit execute-stage ALU: control
//             code constants, the operation enum and a small decode helper.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] ALU_PASS_B   = 3'b000;
    localparam logic [2:0] ALU_ADD      = 3'b010;
    localparam logic [2:0] ALU_SUBTRACT = 3'b011;
    localparam logic [2:0] ALU_AND      = 3'b100;
    localparam logic [2:0] ALU_OR       = 3'b101;
    localparam logic [2:0] ALU_XOR      = 3'b110;

    // Reserved encodings are listed so any 3-bit value casts to a legal member.
    typedef enum logic [2:0] {
        OP_PASS_B = 3'b000,
        OP_RSVD1  = 3'b001,
        OP_ADD    = 3'b010,
        OP_SUB    = 3'b011,
        OP_AND    = 3'b100,
        OP_OR     = 3'b101,
        OP_XOR    = 3'b110,
        OP_RSVD7  = 3'b111
    } alu_op_t;

    // True for the two codes that use the adder and report carry/overflow.
    function automatic logic is_arith(input logic [2:0] code);
        return (code == ALU_ADD) || (code == ALU_SUBTRACT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_64_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_64_if
//  Purpose  : Operand/result bundle for alu_64.
//  Ports    : A, B, cntrl       - operands and operation select (to ALU)
//             result, negative, zero, overflow, carry_out - registered outputs
//  Modports : master (operand source), slave (the ALU)
//  Revision : 1.0  initial release
// ============================================================================
interface alu_64_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       cntrl;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry_out;

    modport master (
        output A, B, cntrl,
        input  result, negative, zero, overflow, carry_out
    );

    modport slave (
        input  A, B, cntrl,
        output result, negative, zero, overflow, carry_out
    );
endinterface
`default_nettype wire

// File: rtl/alu_bitslice.sv
`default_nettype none
// ============================================================================
//  Module   : alu_bitslice
//  Purpose  : One bit of the ALU datapath: full adder with optional B
//             inversion, AND/OR/XOR, and a per-bit result mux.
//  Ports    : a_i, b_i   - operand bits
//             cin_i      - carry in from the lower slice
//             cntrl_i    - operation select
//             res_o      - selected result bit
//             cout_o     - carry out to the next slice
//  Revision : 1.0  initial release
// ============================================================================
module alu_bitslice
    import alu_pkg::*;
(
    input  wire logic       a_i,
    input  wire logic       b_i,
    input  wire logic       cin_i,
    input  wire logic [2:0] cntrl_i,
    output logic            res_o,
    output logic            cout_o
);

    logic    b_eff;
    logic    sum;
    alu_op_t op;

    // cntrl[0] distinguishes SUB from ADD; inverting B here plus a carry-in of
    // 1 at slice 0 gives A + ~B + 1.
    assign b_eff  = b_i ^ cntrl_i[0];
    assign sum    = a_i ^ b_eff ^ cin_i;
    assign cout_o = (a_i & b_eff) | (cin_i & (a_i ^ b_eff));
    assign op     = alu_op_t'(cntrl_i);

    always_comb begin
        res_o = 1'b0;
        case (op)
            OP_PASS_B:      res_o = b_i;
            OP_ADD, OP_SUB: res_o = sum;
            OP_AND:         res_o = a_i & b_i;
            OP_OR:          res_o = a_i | b_i;
            OP_XOR:         res_o = a_i ^ b_i;
            default:        res_o = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_64.sv
`default_nettype none
// ============================================================================
//  Module   : alu_64
//  Purpose  : 64-bit execute-stage ALU (pass-B, add, sub, and, or, xor) with
//             negative/zero/overflow/carry flags, registered with 1-cycle
//             latency and 1 op/cycle throughput.
//  Ports    : clk      - system clock, rising edge
//             reset_n  - synchronous active-low reset
//             bus      - alu_64_if slave: A, B, cntrl in; result and flags out
//  Revision : 1.0  initial release
// ============================================================================
module alu_64
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  wire logic clk,
    input  wire logic reset_n,
    alu_64_if.slave   bus
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] result_d;
    logic             negative_d;
    logic             zero_d;
    logic             overflow_d;
    logic             carry_out_d;
    logic             arith;

    logic [WIDTH-1:0] result_q;
    logic             negative_q;
    logic             zero_q;
    logic             overflow_q;
    logic             carry_out_q;

    assign arith    = is_arith(bus.cntrl);
    // The +1 of two's-complement subtraction enters as the chain's carry-in.
    assign carry[0] = (bus.cntrl == ALU_SUBTRACT);

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        alu_bitslice u_slice (
            .a_i     (bus.A[i]),
            .b_i     (bus.B[i]),
            .cin_i   (carry[i]),
            .cntrl_i (bus.cntrl),
            .res_o   (result_d[i]),
            .cout_o  (carry[i+1])
        );
    end

    assign negative_d  = result_d[WIDTH-1];
    // Reduction OR maps to a balanced OR tree, keeping zero detect shallow
    // behind the ripple chain.
    assign zero_d      = ~(|result_d);
    // Signed overflow: carry into the MSB disagrees with carry out of it.
    assign overflow_d  = arith & (carry[WIDTH-1] ^ carry[WIDTH]);
    assign carry_out_d = arith & carry[WIDTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            result_q    <= '0;
            negative_q  <= 1'b0;
            zero_q      <= 1'b1;
            overflow_q  <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            negative_q  <= negative_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.negative  = negative_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;
    assign bus.carry_out = carry_out_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_64.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_64
//  Purpose  : Self-checking bench for alu_64. Stimulus is applied on the
//             falling edge; the expected outcome is queued at the same time
//             and compared just after the rising edge that captures it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_64;
    import alu_pkg::*;

    typedef struct {
        string       name;
        logic [63:0] res;
        logic        n;
        logic        z;
        logic        v;
        logic        c;
    } exp_t;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        n;
        logic        z;
        logic        v;
        logic        c;
    } vec_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    alu_64_if #(.WIDTH(64)) bus ();

    alu_64 #(.WIDTH(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: 65-bit sums and sign-rule overflow.
    function automatic exp_t model(input string nm, input logic [2:0] op,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        logic [64:0] wide;
        e.name = nm;
        e.res  = '0;
        e.v    = 1'b0;
        e.c    = 1'b0;
        case (op)
            ALU_PASS_B: e.res = b;
            ALU_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                e.res = wide[63:0];
                e.c   = wide[64];
                e.v   = (a[63] == b[63]) && (e.res[63] != a[63]);
            end
            ALU_SUBTRACT: begin
                e.res = a - b;
                e.c   = (a >= b);
                e.v   = (a[63] != b[63]) && (e.res[63] != a[63]);
            end
            ALU_AND: e.res = a & b;
            ALU_OR:  e.res = a | b;
            ALU_XOR: e.res = a ^ b;
            default: e.res = '0;
        endcase
        e.n = e.res[63];
        e.z = (e.res == 64'd0);
        return e;
    endfunction

    task automatic drive(input logic rn, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] b, input exp_t e);
        @(negedge clk);
        reset_n   = rn;
        bus.cntrl = op;
        bus.A     = a;
        bus.B     = b;
        sb.push_back(e);
    endtask

    task automatic drive_model(input string nm, input logic [2:0] op,
                               input logic [63:0] a, input logic [63:0] b);
        drive(1'b1, op, a, b, model(nm, op, a, b));
    endtask

    // Whatever is queued at a rising edge is exactly what that edge captures.
    always @(posedge clk) begin
        if (sb.size() > 0) begin
            exp_t cur;
            cur = sb.pop_front();
            #1;
            checks++;
            if ({bus.result, bus.negative, bus.zero, bus.overflow, bus.carry_out} !==
                {cur.res, cur.n, cur.z, cur.v, cur.c}) begin
                errors++;
                $display("FAIL %s: got res=%h n=%b z=%b v=%b c=%b, expected res=%h n=%b z=%b v=%b c=%b",
                         cur.name, bus.result, bus.negative, bus.zero, bus.overflow, bus.carry_out,
                         cur.res, cur.n, cur.z, cur.v, cur.c);
            end
        end
    end

    vec_t vecs[12];

    initial begin
        exp_t rst_e;
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.cntrl = ALU_PASS_B;

        vecs[0]  = '{"add_ovf",   ALU_ADD,      64'h7fff_ffff_ffff_ffff, 64'h1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{"sub_1m1",   ALU_SUBTRACT, 64'h1, 64'h1, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{"sub_1m2",   ALU_SUBTRACT, 64'h1, 64'h2, 64'hffff_ffff_ffff_ffff, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{"sub_ovf",   ALU_SUBTRACT, 64'h8000_0000_0000_0000, 64'h1, 64'h7fff_ffff_ffff_ffff, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{"and_neg",   ALU_AND, 64'hf000_0000_0000_0101, 64'hf000_0000_0001_1010, 64'hf000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"or",        ALU_OR,  64'hf000_0000_0000_0101, 64'hf000_0000_0001_1010, 64'hf000_0000_0001_1111, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{"xor",       ALU_XOR, 64'hf000_0000_0000_0101, 64'hf000_0000_0001_1010, 64'h0000_0000_0001_1111, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"and_zero",  ALU_AND, 64'h1100, 64'h0000_0110_0000_0001, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{"rsvd_111",  3'b111,  64'hffff_ffff_ffff_ffff, 64'hffff_ffff_ffff_ffff, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{"rsvd_001",  3'b001,  64'hffff_ffff_ffff_ffff, 64'h1234, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{"add_wrap",  ALU_ADD, 64'hffff_ffff_ffff_ffff, 64'h1, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{"pass_neg",  ALU_PASS_B, 64'h5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};

        rst_e = '{"reset", 64'h0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset held with an ADD 1+1 pending, then released.
        drive(1'b0, ALU_ADD, 64'h1, 64'h1, rst_e);
        drive(1'b0, ALU_ADD, 64'h1, 64'h1, rst_e);
        drive(1'b1, ALU_ADD, 64'h1, 64'h1, '{"post_reset", 64'h2, 1'b0, 1'b0, 1'b0, 1'b0});

        // Directed table, back to back.
        foreach (vecs[i])
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b,
                  '{vecs[i].name, vecs[i].res, vecs[i].n, vecs[i].z, vecs[i].v, vecs[i].c});

        // cntrl changes every cycle on the same operands.
        drive(1'b1, ALU_ADD,      64'h10, 64'h3, '{"b2b_add", 64'h13, 1'b0, 1'b0, 1'b0, 1'b0});
        drive(1'b1, ALU_SUBTRACT, 64'h10, 64'h3, '{"b2b_sub", 64'h0d, 1'b0, 1'b0, 1'b0, 1'b1});
        drive(1'b1, ALU_XOR,      64'h10, 64'h3, '{"b2b_xor", 64'h13, 1'b0, 1'b0, 1'b0, 1'b0});

        // Reset wins over a live operation and clears a nonzero result.
        drive(1'b1, ALU_SUBTRACT, 64'h0, 64'h1, '{"pre_rst", 64'hffff_ffff_ffff_ffff, 1'b1, 1'b0, 1'b0, 1'b0});
        drive(1'b0, ALU_SUBTRACT, 64'h0, 64'h1, rst_e);

        // ADD/SUB sweep in steps of 0xF, low values and with sign bits set.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic [63:0] a;
                logic [63:0] b;
                a = 64'(i) * 64'hF;
                b = 64'(j) * 64'hF;
                drive_model("sweep_add", ALU_ADD, a, b);
                drive_model("sweep_sub", ALU_SUBTRACT, a, b);
                a = {4'(i), 60'h0} + a;
                b = {4'(15 - j), 60'hfff_ffff_ffff_fff0} + b;
                drive_model("sweep_add_hi", ALU_ADD, a, b);
                drive_model("sweep_sub_hi", ALU_SUBTRACT, a, b);
            end
        end

        // PASS_B with random operands, plus a zero B.
        for (int k = 0; k < 100; k++)
            drive_model("pass_rand", ALU_PASS_B, {$urandom, $urandom}, {$urandom, $urandom});
        drive_model("pass_zero", ALU_PASS_B, 64'hdead_beef, 64'h0);

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 10 && sb.size() > 0; w++)
            @(negedge clk);
        @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
